seq_slice_adder: RTL and testbench

- Multi-cycle, parametrised add/subtract unit; successor to the single-cycle combinational full adder.
- Splits WIDTH-bit operands into DIGIT-bit slices and adds one slice per clock, rippling the carry through a register.
- Valid/ready handshake on both sides, so it drops into streaming datapaths and testbench-driven harnesses.
- Trades latency for a short critical path (DIGIT-bit adder only).

---
 rtl/seq_slice_adder.sv | 176 +++++++++++++++++
 tb/tb_seq_slice_adder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_slice_adder.sv
// -----------------------------------------------------------------------------
// seq_slice_adder
//   Multi-cycle add/subtract unit. WIDTH-bit operands are processed as
//   NSLICE = WIDTH/DIGIT slices, one slice per clock. The carry between slices
//   is held in a register, so the only adder on the critical path is DIGIT
//   bits wide. Operands come in and results go out over valid/ready handshakes.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand request
//   in_ready   out  high only while idle (decoded from the state register)
//   a, b       in   WIDTH-bit operands
//   c_in       in   carry-in for add, borrow-in for subtract
//   sub        in   0 = a + b + c_in, 1 = a - b - c_in
//   out_valid  out  result available; held until out_ready is sampled high
//   out_ready  in   consumer accepts the result
//   sum        out  WIDTH-bit result, modulo 2^WIDTH
//   c_out      out  carry out of the MSB slice (subtract: 1 = no borrow)
//   ovf        out  signed overflow; present only with SEQ_SLICE_ADDER_OVF_EN
//
// Build option
//   SEQ_SLICE_ADDER_OVF_EN : when defined, adds the ovf output port.
// -----------------------------------------------------------------------------
module seq_slice_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SEQ_SLICE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic             carry_q,     carry_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             c_out_q,     c_out_d;
    logic             out_valid_q, out_valid_d;
`ifdef SEQ_SLICE_ADDER_OVF_EN
    logic             ovf_q,       ovf_d;
`endif

    logic [DIGIT-1:0] a_slice_s;
    logic [DIGIT-1:0] b_slice_s;
    logic [DIGIT:0]   slice_s;
    logic             msb_cin_s;

    // Slice adder: the only arithmetic on the per-cycle path.
    always_comb begin
        a_slice_s = a_q[cnt_q*DIGIT +: DIGIT];
        b_slice_s = b_q[cnt_q*DIGIT +: DIGIT];
        slice_s   = {1'b0, a_slice_s} + {1'b0, b_slice_s} + {{DIGIT{1'b0}}, carry_q};
        // Carry into the top bit of the slice, recovered from its sum bit.
        msb_cin_s = a_slice_s[DIGIT-1] ^ b_slice_s[DIGIT-1] ^ slice_s[DIGIT-1];
    end

    // Control FSM and datapath next-state.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        out_valid_d = out_valid_q;
`ifdef SEQ_SLICE_ADDER_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1; a borrow-in removes the +1.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = c_in ^ sub;
                    cnt_d   = {CW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[cnt_q*DIGIT +: DIGIT] = slice_s[DIGIT-1:0];
                carry_d = slice_s[DIGIT];
                if (cnt_q == LAST_CNT) begin
                    c_out_d     = slice_s[DIGIT];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef SEQ_SLICE_ADDER_OVF_EN
                    ovf_d       = msb_cin_s ^ slice_s[DIGIT];
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
`ifdef SEQ_SLICE_ADDER_OVF_EN
                    ovf_d       = 1'b0;
`endif
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SEQ_SLICE_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
`ifdef SEQ_SLICE_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
`ifdef SEQ_SLICE_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_slice_adder.sv
// Directed and random checks of seq_slice_adder at three parameter sets:
// u_dut0 (8/2), u_dut1 (8/8) and u_dut2 (16/4).
module tb_seq_slice_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  iv_s = 3'b000;
    logic [15:0] a_s = 16'h0000;
    logic [15:0] b_s = 16'h0000;
    logic        cin_s = 1'b0;
    logic        sub_s = 1'b0;
    logic        ordy_s = 1'b0;

    logic        ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2;
    logic [7:0]  s0, s1;
    logic [15:0] s2;
    logic        of0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_slice_adder #(.WIDTH(8), .DIGIT(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_s[0]), .in_ready(ir0),
        .a(a_s[7:0]), .b(b_s[7:0]), .c_in(cin_s), .sub(sub_s),
        .out_valid(ov0), .out_ready(ordy_s), .sum(s0), .c_out(co0)
`ifdef SEQ_SLICE_ADDER_OVF_EN
        , .ovf(of0)
`endif
    );
`ifndef SEQ_SLICE_ADDER_OVF_EN
    assign of0 = 1'b0;
`endif

    seq_slice_adder #(.WIDTH(8), .DIGIT(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_s[1]), .in_ready(ir1),
        .a(a_s[7:0]), .b(b_s[7:0]), .c_in(cin_s), .sub(sub_s),
        .out_valid(ov1), .out_ready(ordy_s), .sum(s1), .c_out(co1)
`ifdef SEQ_SLICE_ADDER_OVF_EN
        , .ovf()
`endif
    );

    seq_slice_adder #(.WIDTH(16), .DIGIT(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_s[2]), .in_ready(ir2),
        .a(a_s), .b(b_s), .c_in(cin_s), .sub(sub_s),
        .out_valid(ov2), .out_ready(ordy_s), .sum(s2), .c_out(co2)
`ifdef SEQ_SLICE_ADDER_OVF_EN
        , .ovf()
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sb;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_ov(input int inst);
        case (inst)
            0:       get_ov = ov0;
            1:       get_ov = ov1;
            default: get_ov = ov2;
        endcase
    endfunction

    // Issue one operation, wait for out_valid (counting edges after the
    // accepting edge), capture the result and optionally complete the transfer.
    task automatic do_op(input int inst, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic sb, input bit release_res,
                         output logic [15:0] rs, output logic rc, output logic rovf,
                         output int lat);
        @(negedge clk);
        a_s = av; b_s = bv; cin_s = ci; sub_s = sb;
        iv_s[inst] = 1'b1;
        @(posedge clk);
        #1;
        iv_s = 3'b000;
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (get_ov(inst)) break;
        end
        case (inst)
            0:       begin rs = {8'h00, s0}; rc = co0; end
            1:       begin rs = {8'h00, s1}; rc = co1; end
            default: begin rs = s2;          rc = co2; end
        endcase
        rovf = of0;
        if (release_res) begin
            @(negedge clk);
            ordy_s = 1'b1;
            @(posedge clk);
            #1;
            ordy_s = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] rs;
        logic        rc, rovf;
        int          lat;

        vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

        // Reset values
        #12;
        chk("rst_in_ready", 32'(ir0), 32'd1);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_sum", 32'(s0), 32'd0);
        chk("rst_c_out", 32'(co0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors on the 8/2 instance
        foreach (vecs[i]) begin
            do_op(0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].cin, vecs[i].sb, 1'b1,
                  rs, rc, rovf, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].exp_sum));
            chk($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].exp_cout));
`ifdef SEQ_SLICE_ADDER_OVF_EN
            chk($sformatf("vec%0d_ovf", i), 32'(rovf), 32'(vecs[i].exp_ovf));
`endif
            chk($sformatf("vec%0d_ready_after", i), 32'(ir0), 32'd1);
            chk($sformatf("vec%0d_valid_after", i), 32'(ov0), 32'd0);
        end

        // Backpressure: result held in DONE, new operands refused
        do_op(0, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, rs, rc, rovf, lat);
        chk("bp_sum_first", 32'(rs), 32'h30);
        @(negedge clk);
        a_s = 16'h0011; b_s = 16'h0001; iv_s[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(ov0), 32'd1);
            chk("bp_sum", 32'(s0), 32'h30);
            chk("bp_c_out", 32'(co0), 32'd0);
            chk("bp_in_ready", 32'(ir0), 32'd0);
        end
        iv_s = 3'b000;
        ordy_s = 1'b1;
        @(posedge clk);
        #1;
        ordy_s = 1'b0;
        chk("bp_release_valid", 32'(ov0), 32'd0);
        chk("bp_release_ready", 32'(ir0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_not_accepted", 32'(ir0), 32'd1);
        chk("bp_sum_kept", 32'(s0), 32'h30);

        // Reset in the middle of RUN
        @(negedge clk);
        a_s = 16'h00FF; b_s = 16'h00FF; cin_s = 1'b0; sub_s = 1'b0; iv_s[0] = 1'b1;
        @(posedge clk);
        #1;
        iv_s = 3'b000;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_run_busy", 32'(ir0), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ov0), 32'd0);
        chk("mid_rst_sum", 32'(s0), 32'd0);
        chk("mid_rst_ready", 32'(ir0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1, rs, rc, rovf, lat);
        chk("post_rst_sum", 32'(rs), 32'h07);
        chk("post_rst_cout", 32'(rc), 32'd0);
        chk("post_rst_lat", 32'(lat), 32'd4);

        // Random sweep on 8/8 and 16/4
        for (int inst = 1; inst < 3; inst++) begin
            int w;
            int modv;
            w = (inst == 1) ? 8 : 16;
            modv = 1 << w;
            for (int n = 0; n < 200; n++) begin
                int av, bv, ci, sb, tot, exp_s, exp_c;
                av = int'($urandom_range(0, modv - 1));
                bv = int'($urandom_range(0, modv - 1));
                ci = int'($urandom_range(0, 1));
                sb = int'($urandom_range(0, 1));
                if (sb == 0) begin
                    tot = av + bv + ci;
                    exp_c = (tot >= modv) ? 1 : 0;
                end else begin
                    tot = av - bv - ci;
                    exp_c = (tot >= 0) ? 1 : 0;
                end
                exp_s = (tot + modv) % modv;
                do_op(inst, 16'(av), 16'(bv), ci[0], sb[0], 1'b1, rs, rc, rovf, lat);
                chk($sformatf("rnd%0d_%0d_lat", inst, n), 32'(lat), (inst == 1) ? 32'd1 : 32'd4);
                chk($sformatf("rnd%0d_%0d_sum", inst, n), 32'(rs), 32'(exp_s));
                chk($sformatf("rnd%0d_%0d_cout", inst, n), 32'(rc), 32'(exp_c));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
